// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the I/D SRAM port arbiter.
// Access sizes, arbiter states and byte-lane/error decoding.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic {
    D_PRIO  = 1'b0,
    I_FORCE = 1'b1
  } arb_state_e;

  function automatic logic [3:0] byte_en(size_e sz);
    logic [3:0] be;
    be = 4'b0000;
    unique case (1'b1)
      sz == SZ_B: be = 4'b0001;
      sz == SZ_H: be = 4'b0011;
      sz == SZ_W: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic access_err(size_e sz, logic [1:0] lo);
    logic err;
    err = 1'b0;
    unique case (1'b1)
      sz == SZ_H:   err = lo[0];
      sz == SZ_W:   err = |lo;
      sz == SZ_RSV: err = 1'b1;
      default:      err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sram_load_ext.sv
// Load-data extension: picks the low byte/half of the SRAM word
// and sign- or zero-extends it to 32 bits.
module sram_load_ext
  import sram_arb_pkg::*;
(
  input  logic [31:0] raw,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    unique case (1'b1)
      size == SZ_B: data = {{24{~uns & raw[7]}}, raw[7:0]};
      size == SZ_H: data = {{16{~uns & raw[15]}}, raw[15:0]};
      default:      data = raw;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM shared by fetch (I) and load/store (D).
// D has priority; I is forced through after STARVE_MAX contested D grants.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_w_en,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [3:0]        starve_cnt;
  logic [3:0]        cnt_nxt;
  size_e             d_sz;
  logic              d_bad;
  logic [ADDR_W-1:0] i_addr_al;
  logic [31:0]       ld_data;

  assign d_sz      = size_e'(d_size);
  assign d_bad     = access_err(d_sz, d_addr[1:0]);
  assign i_addr_al = i_addr & ~ADDR_W'(3);

  sram_load_ext u_ext (
    .raw  (sram_rdata),
    .size (d_sz),
    .uns  (d_unsigned),
    .data (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= D_PRIO;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

  // grants are gated by reset so nothing reaches the SRAM in reset
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      unique case (state)
        D_PRIO: begin
          d_gnt = d_req;
          i_gnt = i_req & ~d_req;
        end
        I_FORCE: begin
          i_gnt = i_req;
          d_gnt = d_req & ~i_req;
        end
        default: begin
          i_gnt = 1'b0;
          d_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cnt_nxt   = starve_cnt;
    state_nxt = D_PRIO;
    if (i_gnt || !i_req) cnt_nxt = '0;
    else if (d_gnt)      cnt_nxt = starve_cnt + 4'd1;
    if (state == D_PRIO && cnt_nxt == 4'(STARVE_MAX))
      state_nxt = I_FORCE;
  end

  always_comb begin
    sram_addr  = d_gnt ? d_addr : i_addr_al;
    sram_wdata = d_wdata;
    sram_w_en  = 4'b0000;
    if (d_gnt && d_we && !d_bad) sram_w_en = byte_en(d_sz);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= i_gnt;
      d_rvalid <= d_gnt;
      d_err    <= d_gnt & d_bad;
      if (i_gnt) i_rdata <= sram_rdata;
      if (d_gnt) d_rdata <= (d_we || d_bad) ? '0 : ld_data;
    end
  end

endmodule
